// File: rtl/ad9914_pkg.sv
// Shared AD9914 parallel-port definitions: read-FSM state encoding and default
// read timing, kept next to the constants used by ad9914_ctrl.
package ad9914_pkg;

  localparam int unsigned AD9914_ADDR_W = 8;
  localparam int unsigned AD9914_DATA_W = 8;
  localparam int unsigned PHASE_CNT_W   = 16;

  localparam int unsigned RD_SETUP_CLK_NUM_DEF    = 2;
  localparam int unsigned RD_PULSE_CLK_NUM_DEF    = 4;
  localparam int unsigned RD_HOLD_CLK_NUM_DEF     = 2;
  localparam int unsigned GNT_TIMEOUT_CLK_NUM_DEF = 1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_PUSH   = 3'd5,
    ST_DONE   = 3'd6
  } rd_state_e;

endpackage

// File: rtl/ad9914_phase_timer.sv
// Down-counter for one bus phase: load with the phase length, expire is high
// on the final cycle of that phase.
module ad9914_phase_timer
  import ad9914_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PHASE_CNT_W-1:0] load_val,
  output logic                   expire
);

  logic [PHASE_CNT_W-1:0] cnt_d, cnt_q;

  // Next count: reload on phase entry, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val - 16'd1;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == 16'd0);

endmodule

// File: rtl/ad9914_reg_reader.sv
// AD9914 parallel-port register read burst engine with a streaming byte output.
// Defining AD9914_RD_GNT_TIMEOUT_EN adds a bus-grant timeout while in REQ.
module ad9914_reg_reader
  import ad9914_pkg::*;
#(
  parameter int unsigned RD_SETUP_CLK_NUM    = RD_SETUP_CLK_NUM_DEF,
  parameter int unsigned RD_PULSE_CLK_NUM    = RD_PULSE_CLK_NUM_DEF,
  parameter int unsigned RD_HOLD_CLK_NUM     = RD_HOLD_CLK_NUM_DEF,
  parameter int unsigned GNT_TIMEOUT_CLK_NUM = GNT_TIMEOUT_CLK_NUM_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] start_addr,
  input  logic [7:0] byte_count,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       p_rd,
  output logic [7:0] p_addr,
  input  logic [7:0] p_data_in,
  output logic       p_data_tri_select
);

  localparam logic [PHASE_CNT_W-1:0] SETUP_LD = PHASE_CNT_W'(RD_SETUP_CLK_NUM);
  localparam logic [PHASE_CNT_W-1:0] PULSE_LD = PHASE_CNT_W'(RD_PULSE_CLK_NUM);
  localparam logic [PHASE_CNT_W-1:0] HOLD_LD  = PHASE_CNT_W'(RD_HOLD_CLK_NUM);

  rd_state_e              state_d, state_q;
  logic [7:0]             addr_d, addr_q, cnt_d, cnt_q;
  logic [7:0]             m_data_d, m_data_q, p_addr_d, p_addr_q;
  logic                   busy_d, busy_q, bus_req_d, bus_req_q, done_d, done_q;
  logic                   err_d, err_q, m_valid_d, m_valid_q, p_rd_d, p_rd_q;
  logic                   abort_s, load_s, capture_s, phase_expire_s;
  logic                   active_s, bus_phase_s;
  logic [PHASE_CNT_W-1:0] load_val_s;

`ifdef AD9914_RD_GNT_TIMEOUT_EN
  localparam int unsigned      GNT_W    = $clog2(GNT_TIMEOUT_CLK_NUM + 1);
  localparam logic [GNT_W-1:0] GNT_LAST = GNT_W'(GNT_TIMEOUT_CLK_NUM - 1);
  logic [GNT_W-1:0] gnt_cnt_d, gnt_cnt_q;
`endif

  ad9914_phase_timer u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .expire   (phase_expire_s)
  );

  // Next-state, address/count update and phase-timer control.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    abort_s    = 1'b0;
    load_s     = 1'b0;
    load_val_s = SETUP_LD;
    capture_s  = 1'b0;
`ifdef AD9914_RD_GNT_TIMEOUT_EN
    gnt_cnt_d  = gnt_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef AD9914_RD_GNT_TIMEOUT_EN
        gnt_cnt_d = {GNT_W{1'b0}};
`endif
        if (start) begin
          addr_d = start_addr;
          cnt_d  = byte_count;
          if (byte_count == 8'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_gnt) begin
          state_d    = ST_SETUP;
          load_s     = 1'b1;
          load_val_s = SETUP_LD;
        end
`ifdef AD9914_RD_GNT_TIMEOUT_EN
        else if (gnt_cnt_q == GNT_LAST) begin
          state_d = ST_DONE;
          abort_s = 1'b1;
        end else begin
          gnt_cnt_d = gnt_cnt_q + GNT_W'(1);
        end
`else
        else begin
          state_d = ST_REQ;
        end
`endif
      end
      // Losing the grant mid-cycle abandons the byte in flight.
      ST_SETUP: begin
        if (!bus_gnt) begin
          state_d = ST_DONE;
          abort_s = 1'b1;
        end else if (phase_expire_s) begin
          state_d    = ST_STROBE;
          load_s     = 1'b1;
          load_val_s = PULSE_LD;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (!bus_gnt) begin
          state_d = ST_DONE;
          abort_s = 1'b1;
        end else if (phase_expire_s) begin
          state_d    = ST_HOLD;
          load_s     = 1'b1;
          load_val_s = HOLD_LD;
          capture_s  = 1'b1;
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_HOLD: begin
        if (!bus_gnt) begin
          state_d = ST_DONE;
          abort_s = 1'b1;
        end else if (phase_expire_s) begin
          state_d = ST_PUSH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_PUSH: begin
        if (m_ready) begin
          addr_d = addr_q + 8'd1;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_SETUP;
            load_s     = 1'b1;
            load_val_s = SETUP_LD;
          end
        end else begin
          state_d = ST_PUSH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    active_s    = (state_d == ST_REQ) || (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                  (state_d == ST_HOLD) || (state_d == ST_PUSH);
    bus_phase_s = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    busy_d      = active_s;
    bus_req_d   = active_s;
    p_rd_d      = (state_d != ST_STROBE);
    m_valid_d   = (state_d == ST_PUSH);
    done_d      = (state_d == ST_DONE);
    err_d       = abort_s;
    if (bus_phase_s) begin
      p_addr_d = addr_d;
    end else begin
      p_addr_d = p_addr_q;
    end
    if (capture_s) begin
      m_data_d = p_data_in;
    end else begin
      m_data_d = m_data_q;
    end
  end

  // State, burst bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= 8'd0;
      cnt_q     <= 8'd0;
      busy_q    <= 1'b0;
      bus_req_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'd0;
      p_rd_q    <= 1'b1;
      p_addr_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      bus_req_q <= bus_req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      p_rd_q    <= p_rd_d;
      p_addr_q  <= p_addr_d;
    end
  end

`ifdef AD9914_RD_GNT_TIMEOUT_EN
  // Grant-wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt_q <= {GNT_W{1'b0}};
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end
`endif

  assign busy              = busy_q;
  assign bus_req           = bus_req_q;
  assign done              = done_q;
  assign err               = err_q;
  assign m_valid           = m_valid_q;
  assign m_data            = m_data_q;
  assign p_rd              = p_rd_q;
  assign p_addr            = p_addr_q;
  assign p_data_tri_select = 1'b1;

endmodule

// File: doc/ad9914_reg_reader.md
AD9914_REG_READER -- requirements
Module: ad9914_reg_reader

Interface
REQ-001 SHALL have parameter RD_SETUP_CLK_NUM, default 2, number of cycles p_addr is stable before p_rd falls.
REQ-002 SHALL have parameter RD_PULSE_CLK_NUM, default 4, number of cycles p_rd is held low.
REQ-003 SHALL have parameter RD_HOLD_CLK_NUM, default 2, number of cycles p_rd is high with p_addr held after the strobe.
REQ-004 SHALL have parameter GNT_TIMEOUT_CLK_NUM, default 1000, number of REQ-state cycles allowed before the grant times out.
REQ-005 SHALL have one clock and a synchronous, active-high reset, and these SHALL be the first two ports: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have the following ports:
- start  in  1  one-cycle request to begin a read burst.
- start_addr  in  8  first AD9914 register address.
- byte_count  in  8  number of bytes to read.
- busy  out  1  burst in progress.
- done  out  1  one-cycle end-of-burst pulse.
- err  out  1  valid with done; burst aborted.
- m_data  out  8  byte read from the AD9914.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts m_data.
- bus_req  out  1  request for the shared AD9914 parallel bus.
- bus_gnt  in  1  the bus has been granted to this block.
- p_rd  out  1  AD9914 RD strobe, active low.
- p_addr  out  8  AD9914 parallel address.
- p_data_in  in  8  AD9914 parallel data, from the IOBUF O pin.
- p_data_tri_select  out  1  IOBUF T; 1 = FPGA drive released.

Function
REQ-007 SHALL implement the states IDLE, REQ, SETUP, STROBE, HOLD, PUSH and DONE.
REQ-008 SHALL, in IDLE, on start=1 latch start_addr and byte_count and enter REQ on the next cycle, with busy=1 and bus_req=1 from that cycle.
REQ-009 SHALL, on start with byte_count=0, go directly to DONE with err=0, without asserting bus_req and without performing any bus cycle.
REQ-010 SHALL ignore start while busy=1.
REQ-011 SHALL move from REQ to SETUP on the first cycle bus_gnt=1 is sampled.
REQ-012 SHALL drive p_addr with the current address from SETUP through the end of HOLD, with p_rd=1 during SETUP.
REQ-013 SHALL spend exactly RD_SETUP_CLK_NUM cycles in SETUP, exactly RD_PULSE_CLK_NUM cycles in STROBE with p_rd=0, and exactly RD_HOLD_CLK_NUM cycles in HOLD with p_rd=1.
REQ-014 SHALL register p_data_in on the last STROBE cycle, and that registered value SHALL become m_data.
REQ-015 SHALL assert m_valid in PUSH and hold m_data stable until the cycle in which m_valid and m_ready are both 1.
REQ-016 SHALL, after a byte transfer, increment the address modulo 256 (0xFF wraps to 0x00) and decrement the remaining count.
REQ-017 SHALL return to SETUP while bytes remain, and go to DONE otherwise.
REQ-018 SHALL keep bus_req=1 from REQ through PUSH of the last byte, with p_rd=1 whenever the state is not STROBE.
REQ-019 SHALL, if bus_gnt falls during SETUP, STROBE or HOLD, raise p_rd on the next cycle, discard the current byte, and go to DONE with err=1.
REQ-020 SHALL ignore a loss of bus_gnt during PUSH.
REQ-021 SHALL, in DONE, assert done=1 for exactly one cycle with err valid, drop busy and bus_req on that same cycle, and enter IDLE on the next cycle.
REQ-022 SHALL hold p_data_tri_select=1 at all times, so the block never drives the data bus.
REQ-023 SHALL, with m_ready=1 permanently, take RD_SETUP_CLK_NUM+RD_PULSE_CLK_NUM+RD_HOLD_CLK_NUM+1 cycles per byte after the grant.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, enter IDLE regardless of the current state, including mid-burst, and drop any pending m_data.
REQ-025 SHALL, in that reset cycle, set the outputs to: busy=0, done=0, err=0, m_valid=0, m_data=0x00, bus_req=0, p_rd=1, p_addr=0x00, p_data_tri_select=1.

Configuration
REQ-026 SHALL, when macro AD9914_RD_GNT_TIMEOUT_EN is defined, count cycles spent in REQ and, once the count reaches GNT_TIMEOUT_CLK_NUM without a grant, go to DONE with err=1.
REQ-027 SHALL, when AD9914_RD_GNT_TIMEOUT_EN is undefined, wait in REQ indefinitely and omit the timeout counter.

Structure
REQ-028 SHALL place the state encoding typedef and the default timing constants in shared package ad9914_pkg, next to the ad9914_ctrl constants.
REQ-029 SHALL implement the per-phase SETUP/PULSE/HOLD counting in a single sub-module ad9914_phase_timer, which takes a load value and outputs expire.
REQ-030 SHALL keep all other logic, the FSM and the address and count registers, in ad9914_reg_reader.

Verification
REQ-031 SHALL cover: start_addr=0x10, byte_count=3, bus_gnt tied 1, m_ready=1, AD9914 model returns 0xA1/0xB2/0xC3 -> three m_valid beats with those bytes, p_rd low 4 cycles per byte, 9 cycles per byte, done with err=0.
REQ-032 SHALL cover: start_addr=0xFE, byte_count=3 -> p_addr sequence 0xFE, 0xFF, 0x00.
REQ-033 SHALL cover: m_ready held 0 for 20 cycles on byte 1 -> m_data stable and no new p_rd pulse until the handshake completes.
REQ-034 SHALL cover: bus_gnt dropped during STROBE of byte 2 -> p_rd high next cycle, no m_valid for byte 2, done with err=1.
REQ-035 SHALL cover: byte_count=0 -> done one cycle after start, bus_req never asserted; a second start while busy is ignored.
REQ-036 SHALL cover: with AD9914_RD_GNT_TIMEOUT_EN, GNT_TIMEOUT_CLK_NUM=50 and bus_gnt=0 -> done with err=1 after 50 REQ cycles; also rst asserted mid-STROBE -> all outputs at their reset values on the next cycle.
